param_memory: RTL and testbench

Parametrised single-port-address synchronous memory with separate write and read enables, byte-lane write strobes, a configurable pipelined read latency and out-of-range error flags. It is the generalised successor to the fixed 16x32 memory under verification. It sits behind the same UVM bench style, with a driver on the request signals and a monitor on Data_out/Valid_out. One request per clock, fully pipelined, with no back-pressure.

---
 rtl/param_memory.sv | 163 ++++++++++++++++
 tb/tb_param_memory.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// -----------------------------------------------------------------------------
// param_memory
//
// Single-address synchronous memory with separate read and write enables,
// byte-lane write strobes, an RD_LAT-deep pipelined read path and
// out-of-range error reporting. One request per clock, no back-pressure.
//
// Parameters
//   DATA_W  data width in bits (multiple of 8)
//   ADDR_W  address width
//   DEPTH   number of words, 1 .. 2**ADDR_W
//   RD_LAT  read latency in clocks, 1 .. 4
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset (clears array and pipeline)
//   En          request qualifier for Rw_en / Rr_en
//   Address     word address shared by read and write
//   Data_in     write data
//   Wr_be       byte-lane write strobes, bit i covers Data_in[8i+7:8i]
//   Rw_en       write request
//   Rr_en       read request
//   Data_out    registered read data, holds last valid value
//   Valid_out   one-cycle pulse per accepted read
//   Err_out     read out-of-range flag, aligned with Valid_out
//   Wr_err_out  one-cycle pulse after an out-of-range write
// -----------------------------------------------------------------------------
module param_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  En,
    input  logic [ADDR_W-1:0]     Address,
    input  logic [DATA_W-1:0]     Data_in,
    input  logic [DATA_W/8-1:0]   Wr_be,
    input  logic                  Rw_en,
    input  logic                  Rr_en,
    output logic [DATA_W-1:0]     Data_out,
    output logic                  Valid_out,
    output logic                  Err_out,
    output logic                  Wr_err_out
);

    localparam int NB = DATA_W / 8;

    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    generate
        if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
            $error("param_memory: DATA_W must be a non-zero multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("param_memory: DEPTH must be in 1 .. 2**ADDR_W");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("param_memory: RD_LAT must be in 1 .. 4");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;

    // Pipeline stage registers; the last stage drives the outputs directly.
    logic [RD_LAT-1:0] st_v;
    logic [DATA_W-1:0] st_d [RD_LAT];
    logic [RD_LAT-1:0] st_e;

    // Stage inputs: stage 0 takes the accepted read, stage i takes stage i-1.
    logic [RD_LAT-1:0] in_v;
    logic [DATA_W-1:0] in_d [RD_LAT];
    logic [RD_LAT-1:0] in_e;

    assign in_range = ({1'b0, Address} < DEPTH_L);
    assign wr_acc   = En & Rw_en;
    assign rd_acc   = En & Rr_en;

    // Decoded read mux; addresses beyond DEPTH match no word and read as 0,
    // so there is never an out-of-bounds array access.
    always_comb begin
        rd_word = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if (Address == ADDR_W'(w)) begin
                rd_word = mem[w];
            end
        end
    end

    // Array: byte-lane writes, cleared by reset. The read path samples the
    // array combinationally at the same edge, which gives read-first
    // behaviour on a simultaneous read and write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (wr_acc && in_range) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (Address == ADDR_W'(w)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (Wr_be[b]) begin
                            mem[w][8*b +: 8] <= Data_in[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        in_v[0] = rd_acc;
        in_d[0] = in_range ? rd_word : '0;
        in_e[0] = ~in_range;
        for (int i = 1; i < RD_LAT; i++) begin
            in_v[i] = st_v[i-1];
            in_d[i] = st_d[i-1];
            in_e[i] = st_e[i-1];
        end
    end

    // Data only loads with a valid token so the final stage holds the last
    // read value; the error bit is forced low whenever no token is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_v <= '0;
            st_e <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                st_d[i] <= '0;
            end
        end else begin
            st_v <= in_v;
            for (int i = 0; i < RD_LAT; i++) begin
                if (in_v[i]) begin
                    st_d[i] <= in_d[i];
                    st_e[i] <= in_e[i];
                end else begin
                    st_e[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Wr_err_out <= 1'b0;
        end else begin
            Wr_err_out <= wr_acc & ~in_range;
        end
    end

    assign Data_out  = st_d[RD_LAT-1];
    assign Valid_out = st_v[RD_LAT-1];
    assign Err_out   = st_e[RD_LAT-1];

endmodule

// File: tb/tb_param_memory.sv
// -----------------------------------------------------------------------------
// tb_param_memory
//
// Three param_memory instances share one stimulus stream:
//   0: DEPTH=16, RD_LAT=1   1: DEPTH=12, RD_LAT=1   2: DEPTH=16, RD_LAT=3
// A behavioural model per instance pushes the expected {data, err, cycle} of
// every accepted read into a per-instance queue; the monitor pops and compares
// on each Valid_out pulse.
// -----------------------------------------------------------------------------
module tb_param_memory;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  be = '0;
    logic        rw = 1'b0;
    logic        rr = 1'b0;

    logic [31:0] dout [3];
    logic [2:0]  vld;
    logic [2:0]  errb;
    logic [2:0]  wer;

    int          dep [3] = '{16, 12, 16};
    int          lat [3] = '{1, 1, 3};

    logic [31:0] mdl [3][16];
    exp_t        sb [3][$];
    logic [2:0]  exp_wer = '0;
    logic [31:0] last_d [3];
    int          cyc = 0;

    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    param_memory #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .En(en), .Address(addr), .Data_in(din),
        .Wr_be(be), .Rw_en(rw), .Rr_en(rr), .Data_out(dout[0]),
        .Valid_out(vld[0]), .Err_out(errb[0]), .Wr_err_out(wer[0]));

    param_memory #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(1)) u_b (
        .clk(clk), .rst(rst), .En(en), .Address(addr), .Data_in(din),
        .Wr_be(be), .Rw_en(rw), .Rr_en(rr), .Data_out(dout[1]),
        .Valid_out(vld[1]), .Err_out(errb[1]), .Wr_err_out(wer[1]));

    param_memory #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(3)) u_c (
        .clk(clk), .rst(rst), .En(en), .Address(addr), .Data_in(din),
        .Wr_be(be), .Rw_en(rw), .Rr_en(rr), .Data_out(dout[2]),
        .Valid_out(vld[2]), .Err_out(errb[2]), .Wr_err_out(wer[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Model: read-first, then byte-lane write; flushed by reset.
    logic inr;
    exp_t e_new;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int w = 0; w < 16; w++) mdl[k][w] = '0;
                sb[k].delete();
            end
            exp_wer = '0;
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 3; k++) begin
                inr = (int'(addr) < dep[k]);
                if (en && rr) begin
                    e_new.data = inr ? mdl[k][addr] : 32'h0;
                    e_new.err  = ~inr;
                    e_new.due  = cyc + lat[k] - 1;
                    sb[k].push_back(e_new);
                end
                exp_wer[k] = en && rw && !inr;
                if (en && rw && inr) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mdl[k][addr][8*b +: 8] = din[8*b +: 8];
                end
            end
        end
    end

    exp_t e_got;
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) last_d[k] = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("wr_err%0d", k), {31'b0, wer[k]}, {31'b0, exp_wer[k]});
                if (vld[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("unexp_valid%0d", k), {31'b0, vld[k]}, 32'h0);
                    end else begin
                        e_got = sb[k].pop_front();
                        chk($sformatf("data%0d", k), dout[k], e_got.data);
                        chk($sformatf("err%0d", k), {31'b0, errb[k]}, {31'b0, e_got.err});
                        chk($sformatf("lat%0d", k), cyc, e_got.due);
                        last_d[k] = e_got.data;
                    end
                end else begin
                    chk($sformatf("err_idle%0d", k), {31'b0, errb[k]}, 32'h0);
                    chk($sformatf("hold%0d", k), dout[k], last_d[k]);
                end
            end
        end
    end

    task automatic req(input logic e, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic w, input logic r);
        @(negedge clk);
        en = e; addr = a; din = d; be = b; rw = w; rr = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_dout%0d", tag, k), dout[k], 32'h0);
            chk($sformatf("%s_vld%0d", tag, k), {31'b0, vld[k]}, 32'h0);
            chk($sformatf("%s_err%0d", tag, k), {31'b0, errb[k]}, 32'h0);
            chk($sformatf("%s_wer%0d", tag, k), {31'b0, wer[k]}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            last_d[k] = '0;
            for (int w = 0; w < 16; w++) mdl[k][w] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;

        // Read every address after reset
        for (int a = 0; a < 16; a++) req(1'b1, 4'(a), 32'h0, 4'h0, 1'b0, 1'b1);
        idle(4);

        // Byte-lane merge
        req(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        req(1'b1, 4'd3, 32'h0000_0011, 4'b0001, 1'b1, 1'b0);
        req(1'b1, 4'd3, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(4);
        chk("be_merge", dout[0], 32'hDEAD_BE11);

        // Read-first on simultaneous access, then new data on the next edge
        req(1'b1, 4'd5, 32'hAAAA_5555, 4'hF, 1'b1, 1'b0);
        req(1'b1, 4'd5, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
        req(1'b1, 4'd5, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(4);
        chk("rw_new", dout[0], 32'h1234_5678);

        // Out-of-range on the DEPTH=12 instance; En=0 ignores requests
        req(1'b1, 4'd13, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
        req(1'b0, 4'd14, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b1);
        req(1'b1, 4'd13, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(3);
        chk("oor_data", dout[1], 32'h0);
        chk("oor_ok_data", dout[0], 32'hCAFE_F00D);
        req(1'b1, 4'd11, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(3);

        // RD_LAT=3 back-to-back reads of distinct data
        req(1'b1, 4'd0, 32'h1111_0000, 4'hF, 1'b1, 1'b0);
        req(1'b1, 4'd1, 32'h2222_0001, 4'hF, 1'b1, 1'b0);
        req(1'b1, 4'd2, 32'h3333_0002, 4'hF, 1'b1, 1'b0);
        req(1'b1, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1);
        req(1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 1'b1);
        req(1'b1, 4'd2, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(5);
        chk("lat3_last", dout[2], 32'h3333_0002);

        // Reset with reads in flight
        req(1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 1'b1);
        req(1'b1, 4'd2, 32'h0, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        en = 1'b0; rr = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(4);
        req(1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(5);
        chk("post_rst_data", dout[2], 32'h0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            req(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(6);

        for (int k = 0; k < 3; k++)
            chk($sformatf("drain%0d", k), sb[k].size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
